// File: rtl/mem_scheduler_pkg.sv
// Shared types and constants for the three-port memory scheduler.
package mem_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [1:0] PORT_0  = 2'd0;
    localparam logic [1:0] PORT_1  = 2'd1;
    localparam logic [1:0] PORT_2  = 2'd2;
    localparam logic [1:0] NO_PORT = 2'b11;

    // Round-robin successor; NO_PORT is treated like PORT_2 so port 0 follows it.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == PORT_0) ? PORT_1 :
               (p == PORT_1) ? PORT_2 : PORT_0;
    endfunction

endpackage

// File: rtl/mem_scheduler_arb.sv
// rr_arbiter3: combinational round-robin arbiter for three requesters.
// Search starts at the port after last_grant and wraps 2 -> 0.
module rr_arbiter3
    import mem_scheduler_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [2:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] cand;

    // Walk the three ports in rotated priority order, first requester wins.
    always_comb begin
        grant_idx = NO_PORT;
        grant     = '0;
        cand      = next_port(last_grant);
        for (int unsigned i = 0; i < 3; i++) begin
            if (grant_idx == NO_PORT && req[cand]) begin
                grant_idx = cand;
            end
            cand = next_port(cand);
        end
        case (grant_idx)
            PORT_0:  grant = 3'b001;
            PORT_1:  grant = 3'b010;
            PORT_2:  grant = 3'b100;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/mem_scheduler.sv
// mem_scheduler: three-port round-robin front end for a synchronous RAM.
// Each transaction runs IDLE -> ISSUE -> CAPT -> ACK (4 cycles).
// Optional grant counters enabled with `define MEM_SCHED_STATS_EN.
module mem_scheduler
    import mem_scheduler_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic [DATA_W-1:0] wdata_2,
    input  logic [2:0]        we,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_do,
    output logic [15:0]       stat_grants_0,
    output logic [15:0]       stat_grants_1,
    output logic [15:0]       stat_grants_2
);

    state_t            state_q, state_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic              gnt_we_q, gnt_we_d;
    logic [2:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_di_q, mem_di_d;

    logic [2:0]        grant;
    logic [1:0]        grant_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    rr_arbiter3 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // One-hot select of the granted port's command fields.
    always_comb begin
        sel_addr  = ({ADDR_W{grant[0]}} & addr_0)
                  | ({ADDR_W{grant[1]}} & addr_1)
                  | ({ADDR_W{grant[2]}} & addr_2);
        sel_wdata = ({DATA_W{grant[0]}} & wdata_0)
                  | ({DATA_W{grant[1]}} & wdata_1)
                  | ({DATA_W{grant[2]}} & wdata_2);
        sel_we    = |(grant & we);
    end

    // Next-state and registered outputs; RAM command is live only in ISSUE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_we_d     = gnt_we_q;
        ack_d        = '0;
        rdata_d      = rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_di_d     = '0;
        case (state_q)
            IDLE: begin
                if (grant_idx != NO_PORT) begin
                    state_d      = ISSUE;
                    last_grant_d = grant_idx;
                    gnt_we_d     = sel_we;
                    mem_en_d     = 1'b1;
                    mem_we_d     = sel_we;
                    mem_addr_d   = sel_addr;
                    mem_di_d     = sel_wdata;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                if (!gnt_we_q) begin
                    rdata_d = mem_do;
                end
                case (last_grant_q)
                    PORT_0:  ack_d = 3'b001;
                    PORT_1:  ack_d = 3'b010;
                    PORT_2:  ack_d = 3'b100;
                    default: ack_d = '0;
                endcase
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_2;
            gnt_we_q     <= 1'b0;
            ack_q        <= '0;
            rdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_di_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_we_q     <= gnt_we_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_di_q     <= mem_di_d;
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_di   = mem_di_q;

`ifdef MEM_SCHED_STATS_EN
    logic [15:0] stat_q [3];
    logic [15:0] stat_d [3];
    logic        take;

    assign take = (state_q == IDLE) && (grant_idx != NO_PORT);

    // Saturating per-port grant counters.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            stat_d[i] = stat_q[i];
            if (take && grant[i] && stat_q[i] != 16'hFFFF) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q <= '{default: '0};
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_grants_0 = stat_q[0];
    assign stat_grants_1 = stat_q[1];
    assign stat_grants_2 = stat_q[2];
`else
    assign stat_grants_0 = '0;
    assign stat_grants_1 = '0;
    assign stat_grants_2 = '0;
`endif

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed self-checking bench for mem_scheduler with a behavioural sync RAM.
module tb_mem_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [7:0]  addr_0, addr_1, addr_2;
    logic [7:0]  wdata_0, wdata_1, wdata_2;
    logic [2:0]  we;
    logic [2:0]  ack;
    logic [7:0]  rdata;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_di;
    logic        mem_we;
    logic [7:0]  mem_do = 8'h00;
    logic [15:0] stat_grants_0, stat_grants_1, stat_grants_2;

    logic [7:0]  ram [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [7:0]  pl_data = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_scheduler #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .addr_0        (addr_0),
        .addr_1        (addr_1),
        .addr_2        (addr_2),
        .wdata_0       (wdata_0),
        .wdata_1       (wdata_1),
        .wdata_2       (wdata_2),
        .we            (we),
        .ack           (ack),
        .rdata         (rdata),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_di        (mem_di),
        .mem_we        (mem_we),
        .mem_do        (mem_do),
        .stat_grants_0 (stat_grants_0),
        .stat_grants_1 (stat_grants_1),
        .stat_grants_2 (stat_grants_2)
    );

    // Read-first synchronous RAM, plus a bench-side preload path.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_di;
            mem_do <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic set_port(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        case (p)
            0: begin addr_0 = a; wdata_0 = d; we[0] = w; end
            1: begin addr_1 = a; wdata_1 = d; we[1] = w; end
            default: begin addr_2 = a; wdata_2 = d; we[2] = w; end
        endcase
    endtask

    // Single-port transaction from IDLE, checking every phase.
    task automatic run_txn(input int p, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
        logic [2:0] onehot;
        onehot = 3'b001 << p;
        set_port(p, w, a, d);
        req = onehot;
        tick();                                  // ISSUE
        chk({tag, "/issue_en"},   32'(mem_en),   32'd1);
        chk({tag, "/issue_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "/issue_we"},   32'(mem_we),   32'(w));
        chk({tag, "/issue_di"},   32'(mem_di),   32'(d));
        chk({tag, "/issue_ack"},  32'(ack),      32'd0);
        tick();                                  // CAPT
        chk({tag, "/capt_en"},    32'(mem_en),   32'd0);
        chk({tag, "/capt_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "/capt_ack"},   32'(ack),      32'd0);
        tick();                                  // ACK
        chk({tag, "/ack"},        32'(ack),      32'(onehot));
        chk({tag, "/rdata"},      32'(rdata),    32'(exp_rd));
        tick();                                  // back in IDLE
        req = 3'b000;
        we  = 3'b000;
        chk({tag, "/ack_clr"},    32'(ack),      32'd0);
    endtask

    initial begin
        logic [2:0] exp_ack;
        reset = 1'b1;
        req = 3'b000; we = 3'b000;
        addr_0 = 8'h00; addr_1 = 8'h00; addr_2 = 8'h00;
        wdata_0 = 8'h00; wdata_1 = 8'h00; wdata_2 = 8'h00;

        preload(8'h10, 8'hA5);
        preload(8'h30, 8'h5A);
        preload(8'h41, 8'h11);
        preload(8'h42, 8'h22);
        preload(8'h43, 8'h33);
        tick();

        // Reset state
        chk("rst/ack",      32'(ack),      32'd0);
        chk("rst/rdata",    32'(rdata),    32'd0);
        chk("rst/mem_en",   32'(mem_en),   32'd0);
        chk("rst/mem_we",   32'(mem_we),   32'd0);
        chk("rst/mem_addr", 32'(mem_addr), 32'd0);
        chk("rst/mem_di",   32'(mem_di),   32'd0);
        chk("rst/stat0",    32'(stat_grants_0), 32'd0);
        chk("rst/stat2",    32'(stat_grants_2), 32'd0);
        reset = 1'b0;

        // No request: stays idle
        tick();
        tick();
        chk("idle/mem_en", 32'(mem_en), 32'd0);
        chk("idle/ack",    32'(ack),    32'd0);

        // Port 0 read of preloaded 0x10
        run_txn(0, 1'b0, 8'h10, 8'h00, 8'hA5, "t1");

        // Port 1 write 0x3C to 0x20 (rdata holds A5), then port 0 reads it back
        run_txn(1, 1'b1, 8'h20, 8'h3C, 8'hA5, "t2w");
        run_txn(0, 1'b0, 8'h20, 8'h00, 8'h3C, "t2r");

        // Round robin from reset with all three requesting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t3/rst_rdata", 32'(rdata), 32'd0);
        set_port(0, 1'b0, 8'h41, 8'h00);
        set_port(1, 1'b0, 8'h42, 8'h00);
        set_port(2, 1'b0, 8'h43, 8'h00);
        req = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_ack = (k == 3) ? 3'b001 : (k == 7) ? 3'b010 : (k == 11) ? 3'b100 : 3'b000;
            chk($sformatf("t3/en_c%0d", k),  32'(mem_en), 32'((k % 4) == 1));
            chk($sformatf("t3/ack_c%0d", k), 32'(ack),    32'(exp_ack));
            if (k == 1)  chk("t3/addr_p0", 32'(mem_addr), 32'h41);
            if (k == 5)  chk("t3/addr_p1", 32'(mem_addr), 32'h42);
            if (k == 9)  chk("t3/addr_p2", 32'(mem_addr), 32'h43);
            if (k == 3)  chk("t3/rd_p0",   32'(rdata),    32'h11);
            if (k == 7)  chk("t3/rd_p1",   32'(rdata),    32'h22);
            if (k == 11) chk("t3/rd_p2",   32'(rdata),    32'h33);
            if (k == 4)  req[0] = 1'b0;
            if (k == 8)  req[1] = 1'b0;
            if (k == 12) req[2] = 1'b0;
        end

        // Reset asserted during CAPT aborts the transaction
        set_port(0, 1'b0, 8'h10, 8'h00);
        req = 3'b001;
        tick();                                  // ISSUE
        chk("t4/issue_en", 32'(mem_en), 32'd1);
        tick();                                  // CAPT
        reset = 1'b1;
        tick();
        chk("t4/ack",      32'(ack),      32'd0);
        chk("t4/rdata",    32'(rdata),    32'd0);
        chk("t4/mem_en",   32'(mem_en),   32'd0);
        chk("t4/mem_addr", 32'(mem_addr), 32'd0);
        req = 3'b000;
        reset = 1'b0;
        tick();
        chk("t4/no_ack",   32'(ack),      32'd0);
        run_txn(0, 1'b0, 8'h10, 8'h00, 8'hA5, "t4r");

        // Request raised mid-transaction waits for the next IDLE
        set_port(0, 1'b0, 8'h10, 8'h00);
        req = 3'b001;
        tick();                                  // ISSUE (port 0)
        set_port(1, 1'b0, 8'h20, 8'h00);
        req = 3'b011;
        tick();                                  // CAPT
        tick();                                  // ACK
        chk("t5/ack_p0",   32'(ack),   32'b001);
        chk("t5/rd_p0",    32'(rdata), 32'hA5);
        tick();                                  // IDLE
        req = 3'b010;
        chk("t5/idle_en",  32'(mem_en), 32'd0);
        tick();                                  // ISSUE (port 1)
        chk("t5/en_p1",    32'(mem_en),   32'd1);
        chk("t5/addr_p1",  32'(mem_addr), 32'h20);
        tick();
        tick();
        chk("t5/ack_p1",   32'(ack),   32'b010);
        chk("t5/rd_p1",    32'(rdata), 32'h3C);
        tick();
        req = 3'b000;

        // Five grants to port 2 from a clean reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            run_txn(2, 1'b0, 8'h30, 8'h00, 8'h5A, $sformatf("t6_%0d", n));
        end
`ifdef MEM_SCHED_STATS_EN
        chk("t6/stat0", 32'(stat_grants_0), 32'd0);
        chk("t6/stat1", 32'(stat_grants_1), 32'd0);
        chk("t6/stat2", 32'(stat_grants_2), 32'd5);
`else
        chk("t6/stat0", 32'(stat_grants_0), 32'd0);
        chk("t6/stat1", 32'(stat_grants_1), 32'd0);
        chk("t6/stat2", 32'(stat_grants_2), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
